sram_axi_bridge: RTL and testbench

Converts the core's two SRAM-style ports (instruction and data, one-cycle read latency, no handshake) into single-beat transactions on one AXI3 master port, so the pipeline can run against real memory.
- Sits directly downstream of the CPU core's `inst_sram_*` / `data_sram_*` outputs.
- Returns `stallreq` to pipeline control to freeze the core while the bus access is in flight.
- Data accesses take priority over instruction fetches; at most one AXI transaction is outstanding.

---
 rtl/sram_axi_bridge_if.sv | 58 +++++
 rtl/sram_axi_bridge.sv | 152 +++++++++++++++
 tb/tb_sram_axi_bridge.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master-port bundle for the SRAM-to-AXI bridge.
// Single-beat only; read response ID/resp and write response resp are not carried.
interface sram_axi_bridge_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arvalid, input arready,
        input rdata, rvalid, output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        output awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bvalid, output bready
    );

    modport slave (
        input arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input arvalid, output arready,
        output rdata, rvalid, input rready,
        input awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        input awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bvalid, input bready
    );
endinterface

// File: rtl/sram_axi_bridge.sv
// Turns the core's inst/data SRAM ports into single-beat AXI3 accesses.
// Data before fetch, one transaction outstanding, core stalled meanwhile.
module sram_axi_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq,
    sram_axi_bridge_if.master axi
);
    typedef enum logic [2:0] {
        IDLE, D_RA, D_RD, D_WR, D_B, I_RA, I_RD, DONE
    } state_t;

    state_t      state, state_nx;
    logic        d_pend, i_pend;
    logic        aw_done, w_done;
    logic [31:0] d_addr, d_wdata, i_addr;
    logic [3:0]  d_wen;
    logic        ar_v, aw_v, w_v;
    logic        aw_ok, w_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            d_pend          <= 1'b0;
            i_pend          <= 1'b0;
            aw_done         <= 1'b0;
            w_done          <= 1'b0;
            d_addr          <= '0;
            d_wdata         <= '0;
            d_wen           <= '0;
            i_addr          <= '0;
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    d_pend  <= data_sram_en;
                    i_pend  <= inst_sram_en;
                    d_addr  <= data_sram_addr;
                    d_wdata <= data_sram_wdata;
                    d_wen   <= data_sram_wen;
                    i_addr  <= inst_sram_addr;
                end
                D_RD: if (axi.rvalid) begin
                    data_sram_rdata <= axi.rdata;
                    d_pend          <= 1'b0;
                end
                D_WR: begin
                    if (aw_v && axi.awready) aw_done <= 1'b1;
                    if (w_v && axi.wready)   w_done  <= 1'b1;
                end
                D_B: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (axi.bvalid) d_pend <= 1'b0;
                end
                I_RD: if (axi.rvalid) begin
                    inst_sram_rdata <= axi.rdata;
                    i_pend          <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Each write channel retires independently; B waits for both.
    assign aw_ok = aw_done || (aw_v && axi.awready);
    assign w_ok  = w_done  || (w_v && axi.wready);

    always_comb begin
        state_nx    = state;
        ar_v        = 1'b0;
        aw_v        = 1'b0;
        w_v         = 1'b0;
        axi.arid    = 4'd0;
        axi.araddr  = d_addr;
        axi.rready  = 1'b0;
        axi.bready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (data_sram_en && (data_sram_wen != 4'd0))
                    state_nx = D_WR;
                else if (data_sram_en)
                    state_nx = D_RA;
                else if (inst_sram_en)
                    state_nx = I_RA;
            end
            D_RA: begin
                ar_v     = d_pend;
                axi.arid = 4'd1;
                if (ar_v && axi.arready) state_nx = D_RD;
            end
            D_RD: begin
                axi.rready = 1'b1;
                if (axi.rvalid) state_nx = i_pend ? I_RA : DONE;
            end
            D_WR: begin
                aw_v = !aw_done;
                w_v  = !w_done;
                if (aw_ok && w_ok) state_nx = D_B;
            end
            D_B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) state_nx = i_pend ? I_RA : DONE;
            end
            I_RA: begin
                ar_v       = i_pend;
                axi.araddr = i_addr;
                if (ar_v && axi.arready) state_nx = I_RD;
            end
            I_RD: begin
                axi.rready = 1'b1;
                if (axi.rvalid) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
        endcase
    end

    assign axi.arvalid = ar_v;
    assign axi.awvalid = aw_v;
    assign axi.wvalid  = w_v;
    assign axi.awaddr  = d_addr;
    assign axi.wdata   = d_wdata;
    assign axi.wstrb   = d_wen;

    assign axi.arlen   = 4'd0;
    assign axi.arsize  = 3'd2;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.awid    = 4'd1;
    assign axi.awlen   = 4'd0;
    assign axi.awsize  = 3'd2;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.wlast   = 1'b1;

    assign stallreq = ((state != IDLE) && (state != DONE)) ||
                      ((state == IDLE) && (inst_sram_en || data_sram_en));
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: vector table plus corner sequences.
// A wait-programmable AXI slave answers from a fixed memory map.
module tb_sram_axi_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_sram_en = 1'b0;
    logic [31:0] inst_sram_addr = '0;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en = 1'b0;
    logic [3:0]  data_sram_wen = '0;
    logic [31:0] data_sram_addr = '0;
    logic [31:0] data_sram_wdata = '0;
    logic [31:0] data_sram_rdata;
    logic        stallreq;

    sram_axi_bridge_if bus();

    sram_axi_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq),
        .axi             (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ien;
        logic [31:0] iaddr;
        logic        den;
        logic [3:0]  wen;
        logic [31:0] daddr;
        logic [31:0] wdata;
        int          arw;
        int          rw;
        int          aww;
        int          ww;
        int          exp_stall;
        logic [31:0] exp_ir;
        logic [31:0] exp_dr;
        int          exp_ar;
        logic [3:0]  exp_arid;
        int          exp_wr;
        int          exp_awv;
        int          exp_wv;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;

    int ar_wait, r_wait, aw_wait, w_wait, b_wait;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    int ar_hs, aw_hs, w_hs, b_hs, awv_cnt, wv_cnt, proto_err;
    logic [3:0]  first_arid;
    logic [31:0] r_pend, aw_log, w_log, ar_prev_a;
    logic [3:0]  s_log;
    logic        ar_prev_v, ar_prev_hs;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'hBFC00000: return 32'h3C080001;
            32'hBFC00004: return 32'h24090002;
            32'h80001000: return 32'h12345678;
            default:      return a ^ 32'h5A5A0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic clear_slave(input vec_t v);
        ar_wait = v.arw; r_wait = v.rw; aw_wait = v.aww; w_wait = v.ww;
        b_wait = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
        awv_cnt = 0; wv_cnt = 0; proto_err = 0;
        first_arid = 4'hF;
    endtask

    // Slave decides its readies/valids half a cycle ahead of each edge.
    initial begin
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_prev_v = 1'b0; ar_prev_hs = 1'b0; ar_prev_a = '0;
        r_pend = '0;
        forever begin
            @(negedge clk);
            if (bus.arvalid) begin
                if (ar_prev_v && !ar_prev_hs && bus.araddr != ar_prev_a)
                    proto_err++;
                bus.arready = (ar_cnt >= ar_wait);
                ar_cnt++;
                if (bus.arready) begin
                    ar_hs++;
                    if (ar_hs == 1) first_arid = bus.arid;
                    r_pend = mem(bus.araddr);
                end
            end else begin
                if (ar_prev_v && !ar_prev_hs) proto_err++;
                bus.arready = 1'b0;
                ar_cnt = 0;
            end
            ar_prev_v  = bus.arvalid;
            ar_prev_a  = bus.araddr;
            ar_prev_hs = bus.arvalid && bus.arready;

            if (bus.rready) begin
                bus.rvalid = (r_cnt >= r_wait);
                bus.rdata  = bus.rvalid ? r_pend : 32'hDEADBEEF;
                r_cnt++;
            end else begin
                bus.rvalid = 1'b0;
                r_cnt = 0;
            end

            if (bus.awvalid) begin
                awv_cnt++;
                bus.awready = (aw_cnt >= aw_wait);
                aw_cnt++;
                if (bus.awready) begin
                    aw_hs++;
                    aw_log = bus.awaddr;
                end
            end else begin
                bus.awready = 1'b0;
                aw_cnt = 0;
            end

            if (bus.wvalid) begin
                wv_cnt++;
                bus.wready = (w_cnt >= w_wait);
                w_cnt++;
                if (bus.wready) begin
                    w_hs++;
                    w_log = bus.wdata;
                    s_log = bus.wstrb;
                end
            end else begin
                bus.wready = 1'b0;
                w_cnt = 0;
            end

            if (bus.bready) begin
                if (aw_hs <= b_hs || w_hs <= b_hs) proto_err++;
                bus.bvalid = (b_cnt >= b_wait);
                b_cnt++;
                if (bus.bvalid) b_hs++;
            end else begin
                bus.bvalid = 1'b0;
                b_cnt = 0;
            end
        end
    end

    task automatic run(input vec_t v, output int n);
        clear_slave(v);
        @(negedge clk);
        inst_sram_en    = v.ien;
        inst_sram_addr  = v.iaddr;
        data_sram_en    = v.den;
        data_sram_wen   = v.wen;
        data_sram_addr  = v.daddr;
        data_sram_wdata = v.wdata;
        n = 0;
        #1;
        while (stallreq === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        inst_sram_en = 1'b0;
        data_sram_en = 1'b0;
    endtask

    task automatic check_vec(input vec_t v, input int n, input string tag);
        chk({tag, ".stall_cycles"}, n, v.exp_stall);
        chk({tag, ".done_stall"}, {31'd0, stallreq}, 32'd0);
        chk({tag, ".inst_rdata"}, inst_sram_rdata, v.exp_ir);
        chk({tag, ".data_rdata"}, data_sram_rdata, v.exp_dr);
        chk({tag, ".ar_count"}, ar_hs, v.exp_ar);
        if (v.exp_ar > 0) chk({tag, ".first_arid"}, {28'd0, first_arid},
                              {28'd0, v.exp_arid});
        chk({tag, ".aw_count"}, aw_hs, v.exp_wr);
        chk({tag, ".w_count"}, w_hs, v.exp_wr);
        chk({tag, ".b_count"}, b_hs, v.exp_wr);
        if (v.exp_wr > 0) begin
            chk({tag, ".awaddr"}, aw_log, v.daddr);
            chk({tag, ".wdata"}, w_log, v.wdata);
            chk({tag, ".wstrb"}, {28'd0, s_log}, {28'd0, v.wen});
        end
        chk({tag, ".awvalid_cycles"}, awv_cnt, v.exp_awv);
        chk({tag, ".wvalid_cycles"}, wv_cnt, v.exp_wv);
        chk({tag, ".protocol"}, proto_err, 0);
    endtask

    vec_t tbl[5];
    vec_t fv;
    int   n;
    logic [11:0] pat;

    initial begin
        // fetch only
        tbl[0] = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0,
                   0, 0, 0, 0, 3, 32'h3C080001, 32'h0,
                   1, 4'd0, 0, 0, 0};
        // data read then fetch
        tbl[1] = '{1'b1, 32'hBFC00004, 1'b1, 4'h0, 32'h80001000, 32'h0,
                   0, 0, 0, 0, 5, 32'h24090002, 32'h12345678,
                   2, 4'd1, 0, 0, 0};
        // write then fetch, zero wait
        tbl[2] = '{1'b1, 32'hBFC00000, 1'b1, 4'b0011, 32'h80002000,
                   32'hAABBCCDD, 0, 0, 0, 0, 5, 32'h3C080001, 32'h12345678,
                   1, 4'd0, 1, 1, 1};
        // read with arready late 4, rvalid late 3
        tbl[3] = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h80000010, 32'h0,
                   4, 3, 0, 0, 10, 32'h3C080001, 32'hDA5A0010,
                   1, 4'd1, 0, 0, 0};
        // write only, awready late 2, wready immediate
        tbl[4] = '{1'b0, 32'h0, 1'b1, 4'b0011, 32'h80002004,
                   32'hAABBCCDD, 0, 0, 2, 0, 5, 32'h3C080001, 32'hDA5A0010,
                   0, 4'd0, 1, 3, 1};

        repeat (3) @(negedge clk);
        #1;
        chk("reset.stallreq", {31'd0, stallreq}, 32'd0);
        chk("reset.valids", {27'd0, bus.arvalid, bus.rready, bus.awvalid,
                             bus.wvalid, bus.bready}, 32'd0);
        chk("reset.inst_rdata", inst_sram_rdata, 32'h0);
        chk("reset.data_rdata", data_sram_rdata, 32'h0);
        chk("const.fields", {9'd0, bus.arlen, bus.awlen, bus.arsize,
                             bus.awsize, bus.arburst, bus.awburst, bus.wlast,
                             bus.awid},
            {9'd0, 4'd0, 4'd0, 3'd2, 3'd2, 2'b01, 2'b01, 1'b1, 4'd1});
        chk("const.zero", {31'd0, |{bus.arlock, bus.awlock, bus.arcache,
                                    bus.awcache, bus.arprot, bus.awprot}},
            32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run(tbl[i], n);
            check_vec(tbl[i], n, $sformatf("vec%0d", i));
        end

        // reset in the middle of a data read
        fv = '{1'b0, 32'h0, 1'b1, 4'h0, 32'h80001000, 32'h0,
               0, 5, 0, 0, 0, 32'h0, 32'h0, 0, 4'd0, 0, 0, 0};
        clear_slave(fv);
        @(negedge clk);
        data_sram_en = 1'b1;
        data_sram_wen = 4'h0;
        data_sram_addr = 32'h80001000;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_mid.rready_before", {31'd0, bus.rready}, 32'd1);
        data_sram_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_mid.valids", {27'd0, bus.arvalid, bus.rready, bus.awvalid,
                               bus.wvalid, bus.bready}, 32'd0);
        chk("rst_mid.stallreq", {31'd0, stallreq}, 32'd0);
        chk("rst_mid.inst_rdata", inst_sram_rdata, 32'h0);
        chk("rst_mid.data_rdata", data_sram_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        fv = '{1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0,
               0, 0, 0, 0, 3, 32'h3C080001, 32'h0, 1, 4'd0, 0, 0, 0};
        run(fv, n);
        check_vec(fv, n, "after_rst");

        // back-to-back fetches with en held high
        fv = '{1'b1, 32'hBFC00004, 1'b0, 4'h0, 32'h0, 32'h0,
               0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 4'd0, 0, 0, 0};
        clear_slave(fv);
        @(negedge clk);
        inst_sram_en = 1'b1;
        inst_sram_addr = 32'hBFC00004;
        #1;
        pat[0] = stallreq;
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            #1;
            pat[i] = stallreq;
        end
        inst_sram_en = 1'b0;
        chk("b2b.stall_pattern", {20'd0, pat}, {20'd0, 12'b0111_0111_0111});
        chk("b2b.ar_count", ar_hs, 3);
        chk("b2b.inst_rdata", inst_sram_rdata, 32'h24090002);
        chk("b2b.protocol", proto_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
